ccip_c1_tx_buffer: RTL and testbench

- Elastic buffer on the CCI-P Tx C1 (write-request) channel. It sits directly downstream of the AFU's af2cp_sTxPort.c1 and upstream of the Tx leg of the PR interface register.
- Absorbs write requests issued while the platform asserts c1TxAlmFull, so the AFU sees a buffered almost-full with more slack.
- Drains entries in order, one per cycle, whenever the platform is not almost-full.

---
 rtl/ccip_c1_tx_buffer_pkg.sv | 36 +++
 rtl/ccip_c1_tx_buffer_if.sv | 32 +++
 rtl/ccip_c1_tx_fifo.sv | 58 +++++
 rtl/ccip_c1_tx_buffer.sv | 82 ++++++++
 tb/tb_ccip_c1_tx_buffer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ccip_c1_tx_buffer_pkg.sv
// Shared types for the CCI-P Tx C1 elastic buffer: C1 request header/data, buffered entry, count width.
package ccip_c1_tx_buffer_pkg;

  typedef logic [511:0] t_ccip_clData;

  typedef struct packed {
    logic [5:0]  rsvd2;
    logic [1:0]  vc_sel;
    logic        sop;
    logic        rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    logic               valid;
    t_ccip_clData       data;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
  } t_c1_buf_entry;

  localparam int unsigned C1_ENTRY_W = $bits(t_c1_buf_entry);

  // Entry count needs one bit beyond the pointer width to represent "full".
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ccip_c1_tx_buffer_if.sv
// C1 Tx buffer bus: AFU-side request/almost-full plus status outputs.
// Stats signals exist only when CCIP_C1_TX_BUF_STATS_EN is defined.
interface ccip_c1_tx_buffer_if
  import ccip_c1_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 64
);
  localparam int unsigned CW = cnt_w(DEPTH);

  t_if_ccip_c1_Tx c1Tx_in;
  logic           c1TxAlmFull_in;
  t_if_ccip_c1_Tx c1Tx_out;
  logic           c1TxAlmFull_out;
  logic [CW-1:0]  occupancy;
  logic           overflow_err;
`ifdef CCIP_C1_TX_BUF_STATS_EN
  logic [31:0]    stall_cycles;
  logic [CW-1:0]  peak_occupancy;

  modport master (output c1Tx_in, c1TxAlmFull_in,
                  input  c1Tx_out, c1TxAlmFull_out, occupancy, overflow_err,
                         stall_cycles, peak_occupancy);
  modport slave  (input  c1Tx_in, c1TxAlmFull_in,
                  output c1Tx_out, c1TxAlmFull_out, occupancy, overflow_err,
                         stall_cycles, peak_occupancy);
`else
  modport master (output c1Tx_in, c1TxAlmFull_in,
                  input  c1Tx_out, c1TxAlmFull_out, occupancy, overflow_err);
  modport slave  (input  c1Tx_in, c1TxAlmFull_in,
                  output c1Tx_out, c1TxAlmFull_out, occupancy, overflow_err);
`endif
endinterface

// File: rtl/ccip_c1_tx_fifo.sv
// Single-clock RAM FIFO with combinational read of the head entry; storage is not reset.
module ccip_c1_tx_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_count_next,
  output logic                     o_empty,
  output logic                     o_drop
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_pop, w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  // At full a push is still accepted when the head leaves in the same cycle.
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & ~w_push;

  always_comb begin
    o_count_next = r_count;
    if (w_push && !w_pop)
      o_count_next = r_count + CW'(1);
    else if (!w_push && w_pop)
      o_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= o_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/ccip_c1_tx_buffer.sv
// Elastic buffer on the CCI-P Tx C1 channel with registered output and buffered almost-full.
// Define CCIP_C1_TX_BUF_STATS_EN to add stall_cycles / peak_occupancy.
module ccip_c1_tx_buffer
  import ccip_c1_tx_buffer_pkg::*;
#(
  parameter int unsigned DEPTH         = 64,
  parameter int unsigned ALMFULL_SLACK = 8
) (
  input  logic                 pClk,
  input  logic                 pck_cp2af_softReset,
  ccip_c1_tx_buffer_if.slave   bus
);
  localparam int unsigned   CW        = cnt_w(DEPTH);
  localparam logic [CW-1:0] AF_THRESH = CW'(DEPTH - ALMFULL_SLACK);

  t_c1_buf_entry  w_wdata, w_rdata;
  logic [CW-1:0]  w_count, w_count_next;
  logic           w_empty, w_drop, w_pop;
  t_if_ccip_c1_Tx r_out;
  logic           r_almfull, r_ovf;

  assign w_wdata = '{hdr: bus.c1Tx_in.hdr, data: bus.c1Tx_in.data};
  assign w_pop   = ~w_empty & ~bus.c1TxAlmFull_in;

  ccip_c1_tx_fifo #(
    .DEPTH (DEPTH),
    .W     (C1_ENTRY_W)
  ) u_fifo (
    .clk          (pClk),
    .rst          (pck_cp2af_softReset),
    .i_push       (bus.c1Tx_in.valid),
    .i_pop        (w_pop),
    .i_wdata      (w_wdata),
    .o_rdata      (w_rdata),
    .o_count      (w_count),
    .o_count_next (w_count_next),
    .o_empty      (w_empty),
    .o_drop       (w_drop)
  );

  // Almost-full resets high so the AFU holds off for the first cycle out of reset.
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_out     <= '0;
      r_almfull <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_out.valid <= w_pop;
      if (w_pop) begin
        r_out.hdr  <= w_rdata.hdr;
        r_out.data <= w_rdata.data;
      end
      r_almfull <= (w_count_next >= AF_THRESH);
      r_ovf     <= r_ovf | w_drop;
    end
  end

  assign bus.c1Tx_out        = r_out;
  assign bus.c1TxAlmFull_out = r_almfull;
  assign bus.occupancy       = w_count;
  assign bus.overflow_err    = r_ovf;

`ifdef CCIP_C1_TX_BUF_STATS_EN
  logic [31:0]   r_stall;
  logic [CW-1:0] r_peak;

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      r_stall <= '0;
      r_peak  <= '0;
    end else begin
      if (!w_empty && bus.c1TxAlmFull_in && (r_stall != '1))
        r_stall <= r_stall + 32'd1;
      if (w_count_next > r_peak)
        r_peak <= w_count_next;
    end
  end

  assign bus.stall_cycles   = r_stall;
  assign bus.peak_occupancy = r_peak;
`endif
endmodule

// File: tb/tb_ccip_c1_tx_buffer.sv
// Scoreboard bench for ccip_c1_tx_buffer: stimulus queues expected payloads, a negedge monitor checks outputs.
module tb_ccip_c1_tx_buffer;
  import ccip_c1_tx_buffer_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned SLACK = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ccip_c1_tx_buffer_if #(.DEPTH(DEPTH)) bus ();

  ccip_c1_tx_buffer #(
    .DEPTH         (DEPTH),
    .ALMFULL_SLACK (SLACK)
  ) dut (
    .pClk                (clk),
    .pck_cp2af_softReset (rst),
    .bus                 (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int unsigned seq = 0;
  t_c1_buf_entry sb[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pl(input string name, input t_c1_buf_entry act, input t_c1_buf_entry exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got addr=%0h mdata=%0h data=%h expected addr=%0h mdata=%0h data=%h",
               name, act.hdr.address, act.hdr.mdata, act.data,
               exp.hdr.address, exp.hdr.mdata, exp.data);
    end
  endtask

  function automatic t_c1_buf_entry mk(input int unsigned i);
    t_c1_buf_entry e;
    e = '0;
    e.hdr.req_type = 4'h1;
    e.hdr.address  = 42'h2000 + 42'(i);
    e.hdr.mdata    = 16'(i);
    e.data         = {16{32'hC3C3_0000 | i}};
    return e;
  endfunction

  // Monitor: every valid output must match the oldest expected payload.
  always @(negedge clk) begin : monitor
    t_c1_buf_entry act, exp;
    if (!rst && bus.c1Tx_out.valid === 1'b1) begin
      act = '{hdr: bus.c1Tx_out.hdr, data: bus.c1Tx_out.data};
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got addr=%0h expected no output", act.hdr.address);
      end else begin
        exp = sb.pop_front();
        chk_pl("payload", act, exp);
      end
    end
  end

  task automatic push(input t_c1_buf_entry e, input bit accept);
    bus.c1Tx_in.valid = 1'b1;
    bus.c1Tx_in.hdr   = e.hdr;
    bus.c1Tx_in.data  = e.data;
    if (accept) sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic stop_push();
    bus.c1Tx_in.valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0 && bus.occupancy == '0 && bus.c1Tx_out.valid == 1'b0) break;
      @(posedge clk);
      #1;
    end
    chk({name, "_sb_left"}, sb.size(), 0);
    chk({name, "_occ"}, bus.occupancy, 0);
  endtask

  task automatic single_write(input string name);
    t_c1_buf_entry e;
    e = '0;
    e.hdr.address = 42'h1000;
    e.data        = {64{8'hA5}};
    bus.c1TxAlmFull_in = 1'b0;
    push(e, 1'b1);
    stop_push();
    @(negedge clk);
    chk({name, "_valid_n1"}, bus.c1Tx_out.valid, 0);
    chk({name, "_occ_n1"}, bus.occupancy, 1);
    @(negedge clk);
    chk({name, "_valid_n2"}, bus.c1Tx_out.valid, 1);
    chk({name, "_occ_n2"}, bus.occupancy, 0);
    @(negedge clk);
    chk({name, "_valid_n3"}, bus.c1Tx_out.valid, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin : stim
    t_c1_buf_entry zero_e;
    int run;
    zero_e = '0;
    bus.c1Tx_in        = '0;
    bus.c1TxAlmFull_in = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.c1Tx_out.valid, 0);
    chk_pl("rst_payload", '{hdr: bus.c1Tx_out.hdr, data: bus.c1Tx_out.data}, zero_e);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_ovf", bus.overflow_err, 0);
    chk("rst_almfull", bus.c1TxAlmFull_out, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("almfull_first_cycle", bus.c1TxAlmFull_out, 1);
    @(negedge clk);
    chk("almfull_second_cycle", bus.c1TxAlmFull_out, 0);
    @(posedge clk);
    #1;

    single_write("single");

    // Backpressure: threshold 56 entries
    bus.c1TxAlmFull_in = 1'b1;
    for (int i = 0; i < 56; i++) begin
      if (i == 55) chk("af_before_56th", bus.c1TxAlmFull_out, 0);
      push(mk(seq++), 1'b1);
    end
    stop_push();
    chk("af_after_56th", bus.c1TxAlmFull_out, 1);
    chk("bp_occ", bus.occupancy, 56);
    bus.c1TxAlmFull_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.c1Tx_out.valid) break;
    end
    run = 0;
    while (bus.c1Tx_out.valid && run < 100) begin
      run++;
      @(negedge clk);
    end
    chk("bp_back_to_back", run, 56);
    @(posedge clk);
    #1;
    drain("bp_drain");
    chk("bp_af_released", bus.c1TxAlmFull_out, 0);

    // Fill to full, then push while draining
    bus.c1TxAlmFull_in = 1'b1;
    for (int i = 0; i < 64; i++) push(mk(seq++), 1'b1);
    stop_push();
    chk("full_occ", bus.occupancy, 64);
    chk("full_ovf", bus.overflow_err, 0);
    bus.c1TxAlmFull_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push(mk(seq++), 1'b1);
      chk("simul_occ", bus.occupancy, 64);
    end
    stop_push();
    chk("simul_ovf", bus.overflow_err, 0);
    drain("simul_drain");

    // Overflow: the 65th push is dropped
    bus.c1TxAlmFull_in = 1'b1;
    for (int i = 0; i < 65; i++) push(mk(seq++), i < 64);
    stop_push();
    chk("ovf_occ", bus.occupancy, 64);
    chk("ovf_flag", bus.overflow_err, 1);
    bus.c1TxAlmFull_in = 1'b0;
    drain("ovf_drain");
    chk("ovf_sticky", bus.overflow_err, 1);

    // Reset while streaming out
    bus.c1TxAlmFull_in = 1'b1;
    for (int i = 0; i < 20; i++) push(mk(seq++), 1'b1);
    stop_push();
    chk("mr_occ", bus.occupancy, 20);
    bus.c1TxAlmFull_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.c1Tx_out.valid) break;
    end
    chk("mr_streaming", bus.c1Tx_out.valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_valid_async", bus.c1Tx_out.valid, 0);
    chk("mr_occ_reset", bus.occupancy, 0);
    chk("mr_ovf_reset", bus.overflow_err, 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_almfull_first", bus.c1TxAlmFull_out, 1);
    @(posedge clk);
    #1;
    single_write("post_rst");

`ifdef CCIP_C1_TX_BUF_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("st_stall_rst", bus.stall_cycles, 0);
    chk("st_peak_rst", bus.peak_occupancy, 0);
    bus.c1TxAlmFull_in = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(seq++), 1'b1);
    stop_push();
    repeat (8) @(posedge clk);
    #1 bus.c1TxAlmFull_in = 1'b0;
    chk("st_stall", bus.stall_cycles, 10);
    chk("st_peak", bus.peak_occupancy, 3);
    drain("st_drain");
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
